// File: rtl/cnn.sv
// Binary-image convolution engine: NUM_FEATURES binary KxK kernels are correlated with a
// latched binary image (zero padding, configurable stride), one output pixel per clock.
module cnn #(
    parameter int IMAGE_WIDTH  = 12,
    parameter int IMAGE_HEIGHT = 12,
    parameter int NUM_FEATURES = 1,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1
) (
    input  logic        clk,
    input  logic        rst_cnn,
    input  logic        rst_weights,
    input  logic        image_input [IMAGE_HEIGHT][IMAGE_WIDTH],
    input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0] weights_input,
    input  logic [((NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1)-1:0] feature_writeAddr,
    input  logic        feature_WrEn,
    input  logic        convolution_enable,
    output logic [31:0] outfmap1 [NUM_FEATURES][IMAGE_HEIGHT][IMAGE_WIDTH],
    output logic        conv_done
);

    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int P     = (KERNEL_SIZE - 1) / 2;
    localparam int OUT_H = (IMAGE_HEIGHT - 1) / STRIDE + 1;
    localparam int OUT_W = (IMAGE_WIDTH - 1) / STRIDE + 1;
    localparam int AW    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int RW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            start_s;
    logic            step_s;
    logic            conv_done_r;
    logic [KK-1:0]   mem_r [NUM_FEATURES];
    logic            img_r [IMAGE_HEIGHT][IMAGE_WIDTH];
    logic [AW-1:0]   f_r;
    logic [RW-1:0]   row_r;
    logic [CW-1:0]   col_r;
    logic            f_last_s;
    logic            row_last_s;
    logic            col_last_s;
    logic            last_s;
    logic [31:0]     win_sum_s;

    assign conv_done  = conv_done_r;
    assign f_last_s   = (int'(f_r) == NUM_FEATURES - 1);
    assign row_last_s = (int'(row_r) == OUT_H - 1);
    assign col_last_s = (int'(col_r) == OUT_W - 1);
    assign last_s     = f_last_s && row_last_s && col_last_s;

    // State register and registered done flag
    always_ff @(posedge clk) begin
        if (rst_cnn) begin
            state_r     <= IDLE;
            conv_done_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            conv_done_r <= (next_state_s == DONE);
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (convolution_enable) begin
                    start_s      = 1'b1;
                    next_state_s = CONV;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CONV: begin
                if (convolution_enable) begin
                    step_s       = 1'b1;
                    next_state_s = last_s ? DONE : CONV;
                end else begin
                    next_state_s = CONV;
                end
            end
            DONE: begin
                if (convolution_enable) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Kernel memory; writes are locked out while a run is in progress
    always_ff @(posedge clk) begin
        if (rst_weights) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
                mem_r[f] <= '0;
            end
        end else if (feature_WrEn && (int'(feature_writeAddr) < NUM_FEATURES) && (state_r != CONV)) begin
            mem_r[feature_writeAddr] <= weights_input;
        end
    end

    // Window sum for the current (f,row,col); padding taps contribute nothing
    always_comb begin
        logic [KK-1:0] kernel_v;
        int            row_v;
        int            col_v;
        win_sum_s = 32'd0;
        kernel_v  = '0;
        row_v     = 0;
        col_v     = 0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                kernel_v = mem_r[f_r] >> (i * KERNEL_SIZE + j);
                row_v    = int'(row_r) * STRIDE + i - P;
                col_v    = int'(col_r) * STRIDE + j - P;
                if ((row_v >= 0) && (row_v < IMAGE_HEIGHT) && (col_v >= 0) && (col_v < IMAGE_WIDTH)) begin
                    if (kernel_v[0] && img_r[row_v[RW-1:0]][col_v[CW-1:0]]) begin
                        win_sum_s = win_sum_s + 32'd1;
                    end else begin
                        win_sum_s = win_sum_s;
                    end
                end else begin
                    win_sum_s = win_sum_s;
                end
            end
        end
    end

    // Image latch, output-pixel counters and feature-map storage
    always_ff @(posedge clk) begin
        if (rst_cnn || start_s) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
                for (int r = 0; r < IMAGE_HEIGHT; r++) begin
                    for (int c = 0; c < IMAGE_WIDTH; c++) begin
                        outfmap1[f][r][c] <= 32'd0;
                    end
                end
            end
            for (int r = 0; r < IMAGE_HEIGHT; r++) begin
                for (int c = 0; c < IMAGE_WIDTH; c++) begin
                    img_r[r][c] <= rst_cnn ? 1'b0 : image_input[r][c];
                end
            end
            f_r   <= '0;
            row_r <= '0;
            col_r <= '0;
        end else if (step_s) begin
            outfmap1[f_r][row_r][col_r] <= win_sum_s;
            if (col_last_s) begin
                col_r <= '0;
                if (row_last_s) begin
                    row_r <= '0;
                    f_r   <= f_last_s ? '0 : f_r + AW'(1);
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cnn.sv
// Directed self-checking bench for cnn: stride-1 engine plus a stride-2 engine on shared stimulus.
module tb_cnn;

    logic        clk = 1'b0;
    logic        rst_cnn = 1'b1;
    logic        rst_weights = 1'b1;
    logic        img [12][12];
    logic [8:0]  weights = 9'd0;
    logic [0:0]  waddr = 1'b0;
    logic        wr_en = 1'b0;
    logic        en = 1'b0;
    logic [31:0] fmap_a [1][12][12];
    logic [31:0] fmap_b [1][12][12];
    logic        done_a;
    logic        done_b;

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] X_KERNEL = 9'b101010101;

    always #5 clk = ~clk;

    cnn #(.STRIDE(1)) dut_a (
        .clk(clk), .rst_cnn(rst_cnn), .rst_weights(rst_weights),
        .image_input(img), .weights_input(weights), .feature_writeAddr(waddr),
        .feature_WrEn(wr_en), .convolution_enable(en), .outfmap1(fmap_a), .conv_done(done_a)
    );

    cnn #(.STRIDE(2)) dut_b (
        .clk(clk), .rst_cnn(rst_cnn), .rst_weights(rst_weights),
        .image_input(img), .weights_input(weights), .feature_writeAddr(waddr),
        .feature_WrEn(wr_en), .convolution_enable(en), .outfmap1(fmap_b), .conv_done(done_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_image(input int mode);
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 12; c++) begin
                img[r][c] = (mode == 1) ? 1'b1 : ((mode == 2) ? ((r == 5) && (c == 5)) : 1'b0);
            end
        end
    endtask

    function automatic int exp_ones(input int r, input int c);
        bit rb = (r == 0) || (r == 11);
        bit cb = (c == 0) || (c == 11);
        if (rb && cb) return 2;
        else if (rb || cb) return 3;
        else return 5;
    endfunction

    function automatic int exp_s2(input int r, input int c);
        if ((r >= 6) || (c >= 6)) return 0;
        else if ((r == 0) && (c == 0)) return 2;
        else if ((r == 0) || (c == 0)) return 3;
        else return 5;
    endfunction

    function automatic int exp_pix(input int r, input int c);
        if ((r == 5) && (c == 5)) return 1;
        else if (((r == 4) || (r == 6)) && ((c == 4) || (c == 6))) return 1;
        else return 0;
    endfunction

    initial begin
        set_image(1);
        // ---- reset both domains
        tick(2);
        rst_cnn = 1'b0;
        rst_weights = 1'b0;
        check("reset_done_a", 32'(done_a), 32'd0);
        check("reset_done_b", 32'(done_b), 32'd0);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                check($sformatf("reset_map[%0d][%0d]", r, c), fmap_a[0][r][c], 32'd0);

        // ---- cleared kernel on all-ones image gives zeros
        en = 1'b1;
        tick(145);
        check("zero_kernel_done", 32'(done_a), 32'd1);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                check($sformatf("zero_kernel[%0d][%0d]", r, c), fmap_a[0][r][c], 32'd0);
        en = 1'b0;
        tick(1);
        check("done_drop", 32'(done_a), 32'd0);

        // ---- X kernel, all-ones image, both strides
        weights = X_KERNEL;
        waddr = 1'b0;
        wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
        en = 1'b1;
        tick(36);
        check("s2_done_early", 32'(done_b), 32'd0);
        tick(1);
        check("s2_done_at_36", 32'(done_b), 32'd1);
        tick(107);
        check("s1_done_early", 32'(done_a), 32'd0);
        tick(1);
        check("s1_done_at_144", 32'(done_a), 32'd1);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++) begin
                check($sformatf("ones_s1[%0d][%0d]", r, c), fmap_a[0][r][c], 32'(exp_ones(r, c)));
                check($sformatf("ones_s2[%0d][%0d]", r, c), fmap_b[0][r][c], 32'(exp_s2(r, c)));
            end
        en = 1'b0;
        tick(1);

        // ---- single pixel with a 5-cycle pause, a blocked write and an image change mid-run
        set_image(2);
        en = 1'b1;
        tick(51);
        en = 1'b0;
        set_image(1);
        weights = 9'h1FF;
        wr_en = 1'b1;
        tick(5);
        check("pause_done_low", 32'(done_a), 32'd0);
        wr_en = 1'b0;
        en = 1'b1;
        tick(93);
        check("pause_done_early", 32'(done_a), 32'd0);
        tick(1);
        check("pause_done_delayed", 32'(done_a), 32'd1);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                check($sformatf("pixel[%0d][%0d]", r, c), fmap_a[0][r][c], 32'(exp_pix(r, c)));
        en = 1'b0;
        tick(1);

        // ---- weight reset beats a write; out-of-range address ignored
        weights = 9'h1FF;
        wr_en = 1'b1;
        rst_weights = 1'b1;
        tick(1);
        rst_weights = 1'b0;
        waddr = 1'b1;
        tick(1);
        wr_en = 1'b0;
        waddr = 1'b0;
        en = 1'b1;
        tick(145);
        check("wrst_done", 32'(done_a), 32'd1);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                check($sformatf("wrst_map[%0d][%0d]", r, c), fmap_a[0][r][c], 32'd0);
        en = 1'b0;
        tick(1);

        // ---- rst_cnn aborts a run in progress
        weights = X_KERNEL;
        wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
        en = 1'b1;
        tick(11);
        check("mid_run_written", fmap_a[0][0][0], 32'd2);
        check("mid_run_unwritten", fmap_a[0][5][5], 32'd0);
        rst_cnn = 1'b1;
        en = 1'b0;
        tick(1);
        rst_cnn = 1'b0;
        check("abort_map_cleared", fmap_a[0][0][0], 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        tick(3);
        check("abort_stays_idle", fmap_a[0][0][1], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
